game_ctrl: RTL and testbench
============================

# game_ctrl

Top-level game sequencer for the brick-breaker design. It owns the game state (idle, serve, play, pause, over, win), tracks lives, score and remaining bricks, and drives the control strobes consumed by the paddle, ball and display blocks: the paddle run enable, the paddle recentre pulse and the ball launch pulse. It sits between the button front-end and the paddle/ball datapaths, and advances on the per-frame tick from the video timing block.

## Interface
Parameters:
- LIVES, 3: lives at game start (1..7).
- NUM_BRICKS, 40: bricks per level (1..255).
- SERVE_FRAMES, 60: frame ticks spent in SERVE before launch (1..255).

Ports:
- clk  in  1  system clock (single clock domain).
- rst  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- start_button  in  1  level, debounced upstream.
- pause_button  in  1  level, debounced upstream.
- brick_hit  in  1  one-cycle pulse per destroyed brick.
- ball_lost  in  1  one-cycle pulse when the ball passes the paddle.
- game_run  out  1  paddle/ball motion enable.
- paddle_reset  out  1  one-cycle recentre pulse to the paddle.
- ball_launch  out  1  one-cycle launch pulse to the ball.
- lives_left  out  3  remaining lives.
- bricks_left  out  8  remaining bricks.
- score  out  16  bricks destroyed, saturating.
- state  out  3  current state code, for display.

## Operation
- Button edges: start_rise = start_button & ~start_q and pause_rise = pause_button & ~pause_q. start_q and pause_q are the previous-cycle button values.
- State codes: IDLE=0, SERVE=1, PLAY=2, PAUSE=3, OVER=4, WIN=5. Codes 6 and 7 return to IDLE on the next clock.
- IDLE, OVER and WIN behave the same way:
  - game_run=0.
  - start_rise enters SERVE and starts a new game: lives_left=LIVES, bricks_left=NUM_BRICKS, score=0, paddle_reset pulses.
- SERVE:
  - game_run=1, so the paddle can move before launch.
  - serve_cnt clears on entry and increments on each frame_tick.
  - A frame_tick while serve_cnt==SERVE_FRAMES-1 enters PLAY and pulses ball_launch.
  - brick_hit, ball_lost and pause are ignored.
- PLAY, game_run=1. Events are evaluated in the same cycle, in this order:
  - brick_hit: score+1 (saturates at 16'hFFFF) and bricks_left-1. If bricks_left was 1, go to WIN. WIN beats everything else that cycle, including ball_lost.
  - ball_lost, if not WIN: lives_left-1. If lives_left was 1, go to OVER. Otherwise go to SERVE and pulse paddle_reset.
  - pause_rise, only if neither of the above changed state: go to PAUSE.
- PAUSE:
  - game_run=0.
  - pause_rise returns to PLAY. Counters are untouched and no launch pulse is issued.
  - brick_hit and ball_lost are ignored.
- Widths: counters never wrap. lives_left and bricks_left stop at 0; score saturates.

## Timing
- All outputs are registered and change on the clk edge at which the triggering input is sampled. Latency is one cycle from input to output.
- Each paddle_reset or ball_launch event produces a pulse exactly one cycle wide.
- ball_launch rises on the edge that samples the SERVE_FRAMES-th frame_tick after SERVE entry.
- rst is synchronous and has priority over every event. After the edge with rst=1:
  - state=IDLE.
  - game_run=0, paddle_reset=0, ball_launch=0.
  - lives_left=LIVES, bricks_left=NUM_BRICKS, score=0, serve_cnt=0.
  - start_q=1 and pause_q=1. This blocks a spurious edge from a button already held through reset.
- Reset mid-game (any state) discards the game; no pulse is emitted on the reset edge.
- A start_button held continuously produces only one start_rise.

## Structure
- Package game_pkg holds:
  - the state enum (3-bit) and its codes;
  - the widths LIVES_W=3, BRICK_W=8, SCORE_W=16.
- Sub-module edge_rise: 1-bit rising-edge detector with a synchronous reset preset of 1. It is instantiated for start and for pause.
- The FSM and counters live in one registered process, with a separate next-state block.

## Test plan
- Reset, then start pulse with SERVE_FRAMES=4 -> state=1 and paddle_reset=1 for 1 cycle. After the 4th frame_tick, ball_launch=1 for 1 cycle and state=2.
- In PLAY with lives=3, pulse ball_lost 3 times, each followed by a full serve -> lives 2, 1, then state=4 (OVER) with game_run=0. paddle_reset pulses on the first two losses only.
- NUM_BRICKS=2, two brick_hit pulses -> score=2, bricks_left=0, state=5 (WIN). Repeat with ball_lost coincident with the final brick_hit -> WIN, lives unchanged.
- pause_rise in PLAY -> state=3, game_run=0. brick_hit during PAUSE leaves score unchanged. A second pause_rise -> state=2, no ball_launch.
- Hold start_button through reset and release afterwards -> remains IDLE. A fresh press -> SERVE.
- Assert rst mid-PLAY with score=5 -> next cycle state=0, score=0, lives=LIVES, all pulses 0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and widths for the brick-breaker game sequencer.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package game_pkg;

    localparam int LIVES_W = 3;
    localparam int BRICK_W = 8;
    localparam int SCORE_W = 16;

    // Codes are visible on the display port, so they are pinned explicitly.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_OVER  = 3'd4,
        ST_WIN   = 3'd5
    } state_e;

    // Score increment that sticks at all-ones instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (&v) ? v : v + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/game_if.sv
// Event inputs and status/strobe outputs of the game sequencer.
// Latency: n/a (wiring only).
// Backpressure: none; all events are single-cycle pulses or levels.
interface game_if;

    logic                         frame_tick;
    logic                         start_button;
    logic                         pause_button;
    logic                         brick_hit;
    logic                         ball_lost;
    logic                         game_run;
    logic                         paddle_reset;
    logic                         ball_launch;
    logic [game_pkg::LIVES_W-1:0] lives_left;
    logic [game_pkg::BRICK_W-1:0] bricks_left;
    logic [game_pkg::SCORE_W-1:0] score;
    logic [2:0]                   state;

    // Environment side: buttons, video timing and collision logic.
    modport master (
        output frame_tick, start_button, pause_button, brick_hit, ball_lost,
        input  game_run, paddle_reset, ball_launch, lives_left, bricks_left, score, state
    );

    // Sequencer side.
    modport slave (
        input  frame_tick, start_button, pause_button, brick_hit, ball_lost,
        output game_run, paddle_reset, ball_launch, lives_left, bricks_left, score, state
    );

endinterface

// File: rtl/game_ctrl_edge_rise.sv
// Rising-edge detector for a debounced button level.
// Latency: combinational rise from the current level against last cycle's level.
// Backpressure: none; reset presets history to 1 so a button held through reset never fires.
module edge_rise (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic q;

    // Remember the previous level; reset pretends the button was already pressed.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b1;
        end else begin
            q <= d;
        end
    end

    assign rise = d & ~q;

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: state, lives, bricks, score and paddle/ball control strobes.
// Latency: one cycle; every output is registered on the edge that samples its trigger.
// Backpressure: none; events are consumed in the cycle they arrive or ignored by state.
module game_ctrl
    import game_pkg::*;
#(
    parameter int LIVES        = 3,
    parameter int NUM_BRICKS   = 40,
    parameter int SERVE_FRAMES = 60
) (
    input  logic   clk,
    input  logic   rst,
    game_if.slave  gif
);

    localparam logic [LIVES_W-1:0] LIVES_INIT  = LIVES_W'(LIVES);
    localparam logic [BRICK_W-1:0] BRICKS_INIT = BRICK_W'(NUM_BRICKS);
    localparam logic [7:0]         SERVE_LAST  = 8'(SERVE_FRAMES - 1);

    logic start_rise;
    logic pause_rise;

    state_e               state_q,  state_d;
    logic [LIVES_W-1:0]   lives_q,  lives_d;
    logic [BRICK_W-1:0]   bricks_q, bricks_d;
    logic [SCORE_W-1:0]   score_q,  score_d;
    logic [7:0]           serve_q,  serve_d;
    logic                 prst_d,   launch_d;
    logic                 run_q,    prst_q,   launch_q;

    edge_rise u_start_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (gif.start_button),
        .rise (start_rise)
    );

    edge_rise u_pause_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (gif.pause_button),
        .rise (pause_rise)
    );

    // Next state, counter updates and strobe requests for this cycle's events.
    always_comb begin
        state_d  = state_q;
        lives_d  = lives_q;
        bricks_d = bricks_q;
        score_d  = score_q;
        serve_d  = serve_q;
        prst_d   = 1'b0;
        launch_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_OVER, ST_WIN: begin
                if (start_rise) begin
                    state_d  = ST_SERVE;
                    lives_d  = LIVES_INIT;
                    bricks_d = BRICKS_INIT;
                    score_d  = '0;
                    serve_d  = '0;
                    prst_d   = 1'b1;
                end
            end

            ST_SERVE: begin
                if (gif.frame_tick) begin
                    serve_d = serve_q + 8'd1;
                    if (serve_q == SERVE_LAST) begin
                        state_d  = ST_PLAY;
                        launch_d = 1'b1;
                    end
                end
            end

            ST_PLAY: begin
                // Clearing the last brick wins outright, even if the ball drops that cycle.
                if (gif.brick_hit) begin
                    score_d = sat_inc(score_q);
                    if (bricks_q != '0) begin
                        bricks_d = bricks_q - BRICK_W'(1);
                    end
                    if (bricks_q == BRICK_W'(1)) begin
                        state_d = ST_WIN;
                    end
                end
                if (gif.ball_lost && (state_d != ST_WIN)) begin
                    if (lives_q != '0) begin
                        lives_d = lives_q - LIVES_W'(1);
                    end
                    if (lives_q == LIVES_W'(1)) begin
                        state_d = ST_OVER;
                    end else begin
                        state_d = ST_SERVE;
                        serve_d = '0;
                        prst_d  = 1'b1;
                    end
                end
                // Pause only when nothing above already moved the game elsewhere.
                if (pause_rise && (state_d == ST_PLAY)) begin
                    state_d = ST_PAUSE;
                end
            end

            ST_PAUSE: begin
                if (pause_rise) begin
                    state_d = ST_PLAY;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and output strobes; reset discards any game in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            lives_q  <= LIVES_INIT;
            bricks_q <= BRICKS_INIT;
            score_q  <= '0;
            serve_q  <= '0;
            run_q    <= 1'b0;
            prst_q   <= 1'b0;
            launch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lives_q  <= lives_d;
            bricks_q <= bricks_d;
            score_q  <= score_d;
            serve_q  <= serve_d;
            run_q    <= (state_d == ST_SERVE) || (state_d == ST_PLAY);
            prst_q   <= prst_d;
            launch_q <= launch_d;
        end
    end

    assign gif.game_run     = run_q;
    assign gif.paddle_reset = prst_q;
    assign gif.ball_launch  = launch_q;
    assign gif.lives_left   = lives_q;
    assign gif.bricks_left  = bricks_q;
    assign gif.score        = score_q;
    assign gif.state        = state_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with a behavioural reference model.
// Latency: model advances on each clk edge; outputs compared on the falling edge.
// Backpressure: n/a.
module tb_game_ctrl;

    localparam int P_LIVES  = 3;
    localparam int P_BRICKS = 6;
    localparam int P_SERVE  = 4;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    game_if gif ();

    game_ctrl #(
        .LIVES        (P_LIVES),
        .NUM_BRICKS   (P_BRICKS),
        .SERVE_FRAMES (P_SERVE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .gif (gif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state (plain integers, state named by its display code).
    int m_state, m_lives, m_bricks, m_score, m_frames;
    int m_run, m_prst, m_launch;
    bit m_start_q, m_pause_q, m_valid;

    initial m_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: apply the game rules to the inputs seen at each rising edge.
    always @(posedge clk) begin : model
        bit s_rise, p_rise, won;
        s_rise    = gif.start_button && !m_start_q;
        p_rise    = gif.pause_button && !m_pause_q;
        m_start_q = gif.start_button;
        m_pause_q = gif.pause_button;
        m_prst    = 0;
        m_launch  = 0;
        won       = 0;
        if (rst) begin
            m_state = 0; m_lives = P_LIVES; m_bricks = P_BRICKS; m_score = 0; m_frames = 0;
            m_start_q = 1; m_pause_q = 1; m_valid = 1;
        end else if (m_state == 0 || m_state == 4 || m_state == 5) begin
            if (s_rise) begin
                m_state = 1; m_lives = P_LIVES; m_bricks = P_BRICKS; m_score = 0;
                m_frames = 0; m_prst = 1;
            end
        end else if (m_state == 1) begin
            if (gif.frame_tick) begin
                m_frames++;
                if (m_frames == P_SERVE) begin
                    m_state = 2; m_launch = 1;
                end
            end
        end else if (m_state == 2) begin
            if (gif.brick_hit) begin
                if (m_score < 65535) m_score++;
                if (m_bricks > 0) begin
                    m_bricks--;
                    if (m_bricks == 0) begin
                        won = 1; m_state = 5;
                    end
                end
            end
            if (gif.ball_lost && !won) begin
                if (m_lives > 0) m_lives--;
                if (m_lives == 0) m_state = 4;
                else begin
                    m_state = 1; m_frames = 0; m_prst = 1;
                end
            end else if (p_rise && !won) begin
                m_state = 3;
            end
        end else if (m_state == 3) begin
            if (p_rise) m_state = 2;
        end
        m_run = (m_state == 1 || m_state == 2) ? 1 : 0;
    end

    // Compare every output against the model once reset has been applied.
    always @(negedge clk) begin
        if (m_valid) begin
            check("cmp_state",  gif.state,        m_state);
            check("cmp_run",    gif.game_run,     m_run);
            check("cmp_prst",   gif.paddle_reset, m_prst);
            check("cmp_launch", gif.ball_launch,  m_launch);
            check("cmp_lives",  gif.lives_left,   m_lives);
            check("cmp_bricks", gif.bricks_left,  m_bricks);
            check("cmp_score",  gif.score,        m_score);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_start();
        gif.start_button = 1'b1;
        cyc(1);
        gif.start_button = 1'b0;
    endtask

    task automatic brick();
        gif.brick_hit = 1'b1;
        cyc(1);
        gif.brick_hit = 1'b0;
    endtask

    // Four frame ticks; launch must appear only on the edge sampling the last one.
    task automatic serve();
        for (int i = 1; i <= P_SERVE; i++) begin
            gif.frame_tick = 1'b1;
            cyc(1);
            gif.frame_tick = 1'b0;
            check("serve_launch", gif.ball_launch, (i == P_SERVE) ? 1 : 0);
            check("serve_state",  gif.state,       (i == P_SERVE) ? 2 : 1);
            cyc(1);
        end
        check("launch_width", gif.ball_launch, 0);
    endtask

    initial begin
        gif.frame_tick   = 1'b0;
        gif.start_button = 1'b0;
        gif.pause_button = 1'b0;
        gif.brick_hit    = 1'b0;
        gif.ball_lost    = 1'b0;
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(1);
        check("rst_state",  gif.state,       0);
        check("rst_lives",  gif.lives_left,  3);
        check("rst_bricks", gif.bricks_left, 6);
        check("rst_score",  gif.score,       0);
        check("rst_run",    gif.game_run,    0);

        // Start: one recentre pulse even while the button stays held.
        gif.start_button = 1'b1;
        cyc(1);
        check("start_state", gif.state,        1);
        check("start_prst",  gif.paddle_reset, 1);
        check("start_run",   gif.game_run,     1);
        cyc(1);
        check("start_prst_width", gif.paddle_reset, 0);
        gif.start_button = 1'b0;

        // Events during SERVE are ignored.
        gif.brick_hit = 1'b1; gif.ball_lost = 1'b1; gif.pause_button = 1'b1;
        cyc(1);
        gif.brick_hit = 1'b0; gif.ball_lost = 1'b0; gif.pause_button = 1'b0;
        check("serve_ign_state", gif.state,      1);
        check("serve_ign_score", gif.score,      0);
        check("serve_ign_lives", gif.lives_left, 3);
        serve();

        // Lose all three lives.
        for (int k = 1; k <= 3; k++) begin
            gif.ball_lost = 1'b1;
            cyc(1);
            gif.ball_lost = 1'b0;
            check("lost_lives", gif.lives_left, 3 - k);
            if (k < 3) begin
                check("lost_state", gif.state,        1);
                check("lost_prst",  gif.paddle_reset, 1);
                serve();
            end else begin
                check("over_state", gif.state,        4);
                check("over_run",   gif.game_run,     0);
                check("over_prst",  gif.paddle_reset, 0);
            end
        end

        // New game from OVER; bricks and pause behaviour.
        press_start();
        check("new_state",  gif.state,       1);
        check("new_lives",  gif.lives_left,  3);
        check("new_bricks", gif.bricks_left, 6);
        serve();
        repeat (5) brick();
        check("hits_score",  gif.score,       5);
        check("hits_bricks", gif.bricks_left, 1);
        check("hits_state",  gif.state,       2);
        gif.pause_button = 1'b1;
        cyc(1);
        check("pause_state", gif.state,    3);
        check("pause_run",   gif.game_run, 0);
        brick();
        check("pause_score", gif.score, 5);
        gif.pause_button = 1'b0;
        cyc(1);
        gif.pause_button = 1'b1;
        cyc(1);
        gif.pause_button = 1'b0;
        check("resume_state",  gif.state,       2);
        check("resume_launch", gif.ball_launch, 0);
        check("resume_run",    gif.game_run,    1);

        // Last brick with a coincident ball loss: WIN, lives kept.
        gif.brick_hit = 1'b1; gif.ball_lost = 1'b1;
        cyc(1);
        gif.brick_hit = 1'b0; gif.ball_lost = 1'b0;
        check("win_state",  gif.state,       5);
        check("win_lives",  gif.lives_left,  3);
        check("win_score",  gif.score,       6);
        check("win_bricks", gif.bricks_left, 0);
        check("win_run",    gif.game_run,    0);
        cyc(1);

        // Plain win from a fresh game started out of WIN.
        press_start();
        serve();
        repeat (6) brick();
        check("win2_state", gif.state, 5);

        // Reset mid-PLAY with score 5, start held through reset.
        press_start();
        serve();
        repeat (5) brick();
        check("pre_rst_score", gif.score, 5);
        rst = 1'b1; gif.start_button = 1'b1; gif.brick_hit = 1'b1;
        cyc(1);
        gif.brick_hit = 1'b0;
        check("mid_rst_state",  gif.state,        0);
        check("mid_rst_score",  gif.score,        0);
        check("mid_rst_lives",  gif.lives_left,   3);
        check("mid_rst_prst",   gif.paddle_reset, 0);
        check("mid_rst_launch", gif.ball_launch,  0);
        check("mid_rst_run",    gif.game_run,     0);
        cyc(1);
        rst = 1'b0;
        cyc(3);
        check("held_start_state", gif.state, 0);
        gif.start_button = 1'b0;
        cyc(1);
        gif.start_button = 1'b1;
        cyc(1);
        check("fresh_state", gif.state,        1);
        check("fresh_prst",  gif.paddle_reset, 1);
        gif.start_button = 1'b0;
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
